// File: rtl/led_marquee_ctrl.sv
// LED marquee controller: loads a window of lit LEDs on start and steps it
// around a 16-bit display every STEP_DIV clocks. A button toggles RUN/PAUSE.
// Optional build macro MARQUEE_BOUNCE_EN: when defined, mode 2 bounces the
// window between the display ends. When undefined, mode 2 rotates left.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | display blank, prescaler cleared, waiting for start
// RUN    | prescaler counting, pattern steps when count reaches STEP_DIV-1
// PAUSE  | prescaler and pattern frozen until the next button edge
// (3)    | unreachable encoding, treated as IDLE
module led_marquee_ctrl #(
    parameter int unsigned STEP_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        button,
    input  logic [2:0]  switch,
    input  logic [1:0]  mode,
    output logic [15:0] led,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(STEP_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] led_q, led_d;
    logic [7:0]  presc_q, presc_d;
    logic        button_q;
    logic        btn_edge;
    logic [15:0] led_load;
    logic [15:0] led_step;
`ifdef MARQUEE_BOUNCE_EN
    // 0 = moving left (towards led[15]), 1 = moving right
    logic        dir_q, dir_d, dir_step;
`endif

    assign btn_edge = button & ~button_q;
    // window of switch+1 ones, right-aligned
    assign led_load = 16'hFFFF >> (4'd15 - {1'b0, switch});

    // Pattern produced by one step in the current mode
    always_comb begin
        led_step = led_q;
`ifdef MARQUEE_BOUNCE_EN
        dir_step = dir_q;
`endif
        case (mode)
            2'd0: led_step = {led_q[14:0], led_q[15]};
            2'd1: led_step = {led_q[0], led_q[15:1]};
`ifdef MARQUEE_BOUNCE_EN
            2'd2: begin
                if (!dir_q && led_q[15]) begin
                    dir_step = 1'b1;
                    led_step = {1'b0, led_q[15:1]};
                end else if (dir_q && led_q[0]) begin
                    dir_step = 1'b0;
                    led_step = {led_q[14:0], 1'b0};
                end else if (dir_q) begin
                    led_step = {1'b0, led_q[15:1]};
                end else begin
                    led_step = {led_q[14:0], 1'b0};
                end
            end
`else
            2'd2: led_step = {led_q[14:0], led_q[15]};
`endif
            default: led_step = led_q;
        endcase
    end

    // Next-state logic: stop > start > button edge > step
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        presc_d = presc_q;
`ifdef MARQUEE_BOUNCE_EN
        dir_d   = dir_q;
`endif
        if (stop) begin
            state_d = ST_IDLE;
            led_d   = 16'h0000;
            presc_d = 8'd0;
`ifdef MARQUEE_BOUNCE_EN
            dir_d   = 1'b0;
`endif
        end else if (start) begin
            state_d = ST_RUN;
            led_d   = led_load;
            presc_d = 8'd0;
`ifdef MARQUEE_BOUNCE_EN
            dir_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (btn_edge) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = 8'd0;
                        led_d   = led_step;
`ifdef MARQUEE_BOUNCE_EN
                        dir_d   = dir_step;
`endif
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                end
                ST_PAUSE: begin
                    if (btn_edge) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = 16'h0000;
                    presc_d = 8'd0;
`ifdef MARQUEE_BOUNCE_EN
                    dir_d   = 1'b0;
`endif
                end
            endcase
        end
    end

    // State, pattern, prescaler and button history registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            led_q    <= 16'h0000;
            presc_q  <= 8'd0;
            button_q <= 1'b0;
`ifdef MARQUEE_BOUNCE_EN
            dir_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            presc_q  <= presc_d;
            button_q <= button;
`ifdef MARQUEE_BOUNCE_EN
            dir_q    <= dir_d;
`endif
        end
    end

    assign led   = led_q;
    assign state = state_q;

endmodule

// File: doc/led_marquee_ctrl.md
LED_MARQUEE_CTRL -- requirements
Module: led_marquee_ctrl

Interface
REQ-001 Parameter: STEP_DIV, default 4, number of clk cycles per pattern step; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  load pattern and run; sampled at clk edge.
REQ-005 Port: stop  input  1  return to IDLE, blank display.
REQ-006 Port: button  input  1  level; each rising edge toggles RUN/PAUSE.
REQ-007 Port: switch  input  3  window length L = switch+1 lit LEDs (1..8).
REQ-008 Port: mode  input  2  0 rotate-left, 1 rotate-right, 2 bounce, 3 hold.
REQ-009 Port: led  output  16  registered display pattern.
REQ-010 Port: state  output  2  registered FSM state: 0 IDLE, 1 RUN, 2 PAUSE.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, PAUSE; encoding 3 is unreachable and SHALL decode as IDLE.
REQ-012 Priority per cycle SHALL be: stop > start > button edge > step.
REQ-013 stop=1 in any state: next cycle state=IDLE, led=0x0000, prescaler=0, direction=left.
REQ-014 start=1 (stop=0) in any state: next cycle led=(1<<L)-1, state=RUN, prescaler=0, direction=left; switch sampled only here.
REQ-015 Button edge SHALL be detected as button=1 with previous-cycle button=0 (button_q register).
REQ-016 Edge in RUN: next state PAUSE; edge in PAUSE: next state RUN; edge in IDLE: ignored.
REQ-017 In RUN the prescaler SHALL count 0..STEP_DIV-1 and wrap; a step occurs in the cycle the count equals STEP_DIV-1.
REQ-018 First step SHALL occur STEP_DIV cycles after the load cycle (led changes at edge STEP_DIV after start sampled).
REQ-019 In PAUSE prescaler and led SHALL hold; on resume counting continues from the held value.
REQ-020 mode SHALL be sampled at each step; mode change takes effect on the next step, no reload.
REQ-021 mode 0: led <= {led[14:0],led[15]} (16-bit circular).
REQ-022 mode 1: led <= {led[0],led[15:1]}.
REQ-023 mode 2 (bounce): direction left and led[15]=1 -> direction right, shift right this step; direction right and led[0]=1 -> direction left, shift left this step; otherwise shift in current direction with zero fill.
REQ-024 mode 3: led holds; prescaler keeps counting.
REQ-025 In IDLE led SHALL remain 0x0000 and prescaler 0.

Reset
REQ-026 rst=0 SHALL immediately (asynchronously) force led=0x0000, state=IDLE, prescaler=0, direction=left, button_q=0.
REQ-027 Reset mid-RUN SHALL discard pattern; after release the block waits in IDLE for start.

Configuration
REQ-028 Macro MARQUEE_BOUNCE_EN defined: mode 2 behaves per REQ-023 with a direction register.
REQ-029 Macro MARQUEE_BOUNCE_EN undefined: no direction register; mode 2 SHALL behave exactly as mode 0.

Verification (STEP_DIV=4)
REQ-030 start, switch=2, mode=0 -> led=0x0007 next cycle, 0x000E after 4 more cycles, 0xC001 after 14 steps.
REQ-031 start, switch=0, mode=1 -> led=0x0001, one step later 0x8000 (wrap).
REQ-032 MARQUEE_BOUNCE_EN, start, switch=1, mode=2 -> 0x0003, 0xC000 after 14 steps, 0x6000 at step 15, 0x0003 at step 28, 0x0006 at step 29.
REQ-033 button rising edge in RUN at prescaler=1 -> state=2, led frozen 20 cycles; second edge -> state=1, next step 3 cycles later.
REQ-034 start and stop same cycle in RUN -> state=0, led=0x0000; rst=0 mid-RUN -> led=0x0000 without clock edge.
REQ-035 start and button edge same cycle in RUN -> reload, state=1 (button ignored).
